pux_si_mc: RTL and testbench
============================

Name: pux_si_mc

Overview:
Multi-channel stream interface for the PUX processing unit. It buffers an opcode stream and NCH operand streams in independent FIFOs. For each opcode it issues one command to the execution core, bundled with one word from every operand channel the opcode's mask selects. It also returns core status words on an AXI-Stream status channel and raises a refill request to the fetch DMA when the opcode FIFO runs low. It replaces the fixed single-opcode-FIFO interface with parametrised channel count, depth and threshold.

Parameters:
OPCW, 8, opcode width; bits [NCH-1:0] are the operand-channel mask.
DATAW, 16, operand word width.
STATUSW, 2, status word width.
NCH, 3, number of operand channels (A, B, M by default); 1..OPCW.
FIFOAW, 3, FIFO address width; every FIFO depth = 2**FIFOAW.
REQTHR, 2, stream_request asserts when opcode FIFO level <= REQTHR.

Ports:
axis_clk  in  1  module clock, all logic on rising edge.
axis_rst  in  1  asynchronous reset, active-high.
axis_opcode_data  in  OPCW  opcode stream data.
axis_opcode_valid  in  1  opcode valid.
axis_opcode_ready  out  1  opcode FIFO not full.
axis_opnd_data  in  NCH*DATAW  operand data, channel c at [c*DATAW +: DATAW].
axis_opnd_valid  in  NCH  per-channel valid.
axis_opnd_ready  out  NCH  per-channel FIFO not full.
exec_opcode  out  OPCW  issued opcode.
exec_data  out  NCH*DATAW  issued operands; unselected lanes are 0.
exec_valid  out  1  command valid.
exec_ready  in  1  core accepts command.
exec_done  in  1  one-cycle pulse: core finished a command.
exec_status  in  STATUSW  status word sampled with exec_done.
axis_status_data  out  STATUSW  status stream data.
axis_status_valid  out  1  status valid.
axis_status_ready  in  1  status sink ready.
stream_request  out  1  opcode FIFO low; request a fetch.
opc_level  out  FIFOAW+1  opcode FIFO occupancy, 0..2**FIFOAW.
err_overflow  out  1  sticky: a status word was dropped.

Behaviour:
- Reset: all FIFO pointers 0; exec_valid=0; exec_opcode=0; exec_data=0; axis_status_valid=0; axis_status_data=0; err_overflow=0; opc_level=0. stream_request=1 because level 0 <= REQTHR. All readies=1. Reset mid-operation discards all buffered data immediately.
- FIFO pointers are FIFOAW+1 bits.
  - empty = (wptr == rptr).
  - full = MSB differs and low FIFOAW bits equal.
  - level = wptr - rptr, modulo 2**(FIFOAW+1).
  - Pointers wrap naturally.
- Write rule: on each edge where valid && ready, write the word and increment wptr. ready = !full. ready does not depend on a same-cycle read.
- Issue condition, evaluated each cycle:
  - opcode FIFO not empty, and
  - every channel c with head_opcode[c]=1 is not empty, and
  - (!exec_valid || exec_ready).
- On issue:
  - Pop the opcode and one word from each selected channel.
  - Register exec_opcode and exec_data; set exec_valid=1.
  - Unselected channels are neither popped nor changed.
- When exec_valid && exec_ready without a new issue, exec_valid drops to 0.
- Back-to-back issue gives one command per cycle when data is present and exec_ready=1.
- Mask = 0: the opcode issues with no operands popped.
- Latency: the opcode and its operands are handshaked at edge E0; exec_valid is high after edge E1.
- exec_valid and its outputs are held stable while exec_ready=0.
- Status path is a 1-entry register:
  - exec_done with slot empty, or with slot being emptied this cycle (status valid && ready): load exec_status and set axis_status_valid=1.
  - exec_done while the slot is full and not draining: drop the word and set err_overflow=1. err_overflow clears only on reset.
- stream_request = (opc_level <= REQTHR), combinational from registered pointers.

Decomposition:
- Package pux_si_pkg holds:
  - channel index constants CH_A=0, CH_B=1, CH_M=2;
  - mask field position;
  - status codes ST_OK=2'b00, ST_ERR=2'b01, ST_BUSY=2'b10.
- Sub-module pux_si_fifo: synchronous FIFO with parameters WIDTH and AW, and outputs full, empty and level. Instanced once for opcodes (WIDTH=OPCW) and NCH times for operands (WIDTH=DATAW) via generate.
- The top level holds issue logic, the output register and the status slot.

Test Plan:
1. Reset, then push opcode 8'h03, A=16'h1111, B=16'h2222, exec_ready=1 -> exec_valid one cycle after the handshake edge; exec_opcode=8'h03; exec_data={16'h0000,16'h2222,16'h1111}; the M FIFO is untouched.
2. Push opcode 8'h07 with only A and B supplied -> no issue. Then supply M=16'hBEEF -> issue on the next edge with all three words.
3. Push 8 opcodes with exec_ready=0 (FIFOAW=3) -> after the 8th, axis_opcode_ready=0 and opc_level=8. A 9th valid is not accepted. Then raise exec_ready -> 8 consecutive issues, one per cycle, with pointer wrap verified.
4. stream_request -> 1 at opc_level 2, 0 at opc_level 3, 1 again as the level drains back to 2.
5. exec_done with status 2'b01 while axis_status_ready=0, then a second exec_done -> axis_status_data=2'b01 is held and err_overflow=1. Raise ready -> one transfer of 2'b01.
6. Assert axis_rst while 3 commands are queued and exec_valid=1 -> all outputs return to reset values asynchronously, and opc_level=0.

Source files
------------

// File: rtl/pux_si_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pux_si_pkg : shared constants for the PUX stream interface        |
// | Revision   : 1.0                                                  |
// +------------------------------------------------------------------+
package pux_si_pkg;

   localparam int CH_A = 0;
   localparam int CH_B = 1;
   localparam int CH_M = 2;

   // Operand-channel mask occupies the low bits of the opcode
   localparam int MASK_LSB = 0;

   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_ERR  = 2'b01;
   localparam logic [1:0] ST_BUSY = 2'b10;

endpackage
`default_nettype wire

// File: rtl/pux_si_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pux_si_fifo : synchronous FIFO with wrap-bit pointers             |
// | Revision    : 1.0                                                 |
// +------------------------------------------------------------------+
module pux_si_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   localparam int          DEPTH   = 2**AW;
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign level   = wptr - rptr;
   assign rd_data = mem[rptr[AW-1:0]];
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;

   // Storage needs no reset: pointers alone define what is valid
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_wr) wptr <= wptr + PTR_ONE;
         if (do_rd) rptr <= rptr + PTR_ONE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pux_si_mc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pux_si_mc : multi-channel opcode/operand issue and status return  |
// | Revision  : 1.0                                                   |
// +------------------------------------------------------------------+
module pux_si_mc
   import pux_si_pkg::*;
#(
   parameter int OPCW    = 8,
   parameter int DATAW   = 16,
   parameter int STATUSW = 2,
   parameter int NCH     = 3,
   parameter int FIFOAW  = 3,
   parameter int REQTHR  = 2
) (
   input  logic                 axis_clk,
   input  logic                 axis_rst,
   input  logic [OPCW-1:0]      axis_opcode_data,
   input  logic                 axis_opcode_valid,
   output logic                 axis_opcode_ready,
   input  logic [NCH*DATAW-1:0] axis_opnd_data,
   input  logic [NCH-1:0]       axis_opnd_valid,
   output logic [NCH-1:0]       axis_opnd_ready,
   output logic [OPCW-1:0]      exec_opcode,
   output logic [NCH*DATAW-1:0] exec_data,
   output logic                 exec_valid,
   input  logic                 exec_ready,
   input  logic                 exec_done,
   input  logic [STATUSW-1:0]   exec_status,
   output logic [STATUSW-1:0]   axis_status_data,
   output logic                 axis_status_valid,
   input  logic                 axis_status_ready,
   output logic                 stream_request,
   output logic [FIFOAW:0]      opc_level,
   output logic                 err_overflow
);

   localparam logic [FIFOAW:0] REQ_LEVEL = (FIFOAW+1)'(REQTHR);

   logic [OPCW-1:0]      head_opc;
   logic                 opc_empty;
   logic                 opc_full;
   logic [NCH-1:0]       opnd_empty;
   logic [NCH-1:0]       opnd_full;
   logic [NCH-1:0]       opnd_ok;
   logic [NCH-1:0]       opnd_pop;
   logic [DATAW-1:0]     opnd_head [NCH];
   logic [FIFOAW:0]      unused_opnd_level [NCH];
   logic [NCH*DATAW-1:0] issue_data;
   logic                 issue;
   logic                 status_drain;

   pux_si_fifo #(.WIDTH(OPCW), .AW(FIFOAW)) u_opc_fifo (
      .clk     (axis_clk),
      .rst     (axis_rst),
      .wr_en   (axis_opcode_valid),
      .wr_data (axis_opcode_data),
      .rd_en   (issue),
      .rd_data (head_opc),
      .full    (opc_full),
      .empty   (opc_empty),
      .level   (opc_level)
   );

   generate
      for (genvar c = 0; c < NCH; c++) begin : g_opnd
         pux_si_fifo #(.WIDTH(DATAW), .AW(FIFOAW)) u_opnd_fifo (
            .clk     (axis_clk),
            .rst     (axis_rst),
            .wr_en   (axis_opnd_valid[c]),
            .wr_data (axis_opnd_data[c*DATAW +: DATAW]),
            .rd_en   (opnd_pop[c]),
            .rd_data (opnd_head[c]),
            .full    (opnd_full[c]),
            .empty   (opnd_empty[c]),
            .level   (unused_opnd_level[c])
         );
         assign axis_opnd_ready[c] = !opnd_full[c];
      end
   endgenerate

   assign axis_opcode_ready = !opc_full;

   // A channel blocks issue only when the head opcode selects it and it is empty
   always_comb begin
      opnd_ok    = '1;
      issue_data = '0;
      for (int c = 0; c < NCH; c++) begin
         opnd_ok[c] = !head_opc[MASK_LSB + c] || !opnd_empty[c];
         if (head_opc[MASK_LSB + c]) begin
            issue_data[c*DATAW +: DATAW] = opnd_head[c];
         end
      end
   end

   assign issue    = !opc_empty && (&opnd_ok) && (!exec_valid || exec_ready);
   assign opnd_pop = issue ? head_opc[MASK_LSB +: NCH] : '0;

   always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) begin
         exec_valid  <= 1'b0;
         exec_opcode <= '0;
         exec_data   <= '0;
      end else if (issue) begin
         exec_valid  <= 1'b1;
         exec_opcode <= head_opc;
         exec_data   <= issue_data;
      end else if (exec_ready) begin
         exec_valid  <= 1'b0;
      end
   end

   // Single-entry status slot; a word arriving while it cannot drain is lost
   assign status_drain = axis_status_valid && axis_status_ready;

   always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) begin
         axis_status_valid <= 1'b0;
         axis_status_data  <= '0;
         err_overflow      <= 1'b0;
      end else if (exec_done) begin
         if (!axis_status_valid || status_drain) begin
            axis_status_valid <= 1'b1;
            axis_status_data  <= exec_status;
         end else begin
            err_overflow      <= 1'b1;
         end
      end else if (status_drain) begin
         axis_status_valid <= 1'b0;
      end
   end

   assign stream_request = (opc_level <= REQ_LEVEL);

endmodule
`default_nettype wire

// File: tb/tb_pux_si_mc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pux_si_mc : directed + random bench with queue-based model     |
// | Revision     : 1.0                                                |
// +------------------------------------------------------------------+
module tb_pux_si_mc;
   import pux_si_pkg::*;

   localparam int OPCW = 8, DATAW = 16, STATUSW = 2, NCH = 3, FIFOAW = 3, REQTHR = 2;
   localparam int DEPTH = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [OPCW-1:0]      axis_opcode_data;
   logic                 axis_opcode_valid;
   logic                 axis_opcode_ready;
   logic [NCH*DATAW-1:0] axis_opnd_data;
   logic [NCH-1:0]       axis_opnd_valid;
   logic [NCH-1:0]       axis_opnd_ready;
   logic [OPCW-1:0]      exec_opcode;
   logic [NCH*DATAW-1:0] exec_data;
   logic                 exec_valid;
   logic                 exec_ready;
   logic                 exec_done;
   logic [STATUSW-1:0]   exec_status;
   logic [STATUSW-1:0]   axis_status_data;
   logic                 axis_status_valid;
   logic                 axis_status_ready;
   logic                 stream_request;
   logic [FIFOAW:0]      opc_level;
   logic                 err_overflow;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [OPCW-1:0]  q_opc [$];
   logic [DATAW-1:0] mq [NCH][16];
   int               mcnt [NCH];
   bit               m_valid;
   logic [OPCW-1:0]  m_opc;
   logic [NCH*DATAW-1:0] m_data;
   bit               m_sv;
   logic [STATUSW-1:0] m_sd;
   bit               m_err;

   pux_si_mc #(
      .OPCW(OPCW), .DATAW(DATAW), .STATUSW(STATUSW),
      .NCH(NCH), .FIFOAW(FIFOAW), .REQTHR(REQTHR)
   ) dut (
      .axis_clk          (clk),
      .axis_rst          (rst),
      .axis_opcode_data  (axis_opcode_data),
      .axis_opcode_valid (axis_opcode_valid),
      .axis_opcode_ready (axis_opcode_ready),
      .axis_opnd_data    (axis_opnd_data),
      .axis_opnd_valid   (axis_opnd_valid),
      .axis_opnd_ready   (axis_opnd_ready),
      .exec_opcode       (exec_opcode),
      .exec_data         (exec_data),
      .exec_valid        (exec_valid),
      .exec_ready        (exec_ready),
      .exec_done         (exec_done),
      .exec_status       (exec_status),
      .axis_status_data  (axis_status_data),
      .axis_status_valid (axis_status_valid),
      .axis_status_ready (axis_status_ready),
      .stream_request    (stream_request),
      .opc_level         (opc_level),
      .err_overflow      (err_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      q_opc.delete();
      for (int c = 0; c < NCH; c++) mcnt[c] = 0;
      m_valid = 0; m_opc = '0; m_data = '0;
      m_sv = 0; m_sd = '0; m_err = 0;
   endtask

   task automatic compare_all();
      logic [NCH-1:0] rdy;
      for (int c = 0; c < NCH; c++) rdy[c] = (mcnt[c] < DEPTH);
      check("opcode_ready",   axis_opcode_ready, q_opc.size() < DEPTH);
      check("opnd_ready",     axis_opnd_ready, rdy);
      check("opc_level",      opc_level, q_opc.size());
      check("stream_request", stream_request, q_opc.size() <= REQTHR);
      check("exec_valid",     exec_valid, m_valid);
      check("exec_opcode",    exec_opcode, m_opc);
      check("exec_data",      exec_data, m_data);
      check("status_valid",   axis_status_valid, m_sv);
      check("status_data",    axis_status_data, m_sd);
      check("err_overflow",   err_overflow, m_err);
   endtask

   // Called just after an edge with inputs set: check, advance model, take the edge
   task automatic tick();
      bit acc_o;
      bit acc_c [NCH];
      bit iss;
      bit drain;
      logic [OPCW-1:0] h;
      logic [NCH*DATAW-1:0] nd;
      compare_all();
      acc_o = axis_opcode_valid && (q_opc.size() < DEPTH);
      for (int c = 0; c < NCH; c++) acc_c[c] = axis_opnd_valid[c] && (mcnt[c] < DEPTH);
      iss = (q_opc.size() > 0) && (!m_valid || exec_ready);
      h = '0;
      if (q_opc.size() > 0) begin
         h = q_opc[0];
         for (int c = 0; c < NCH; c++) if (h[c] && mcnt[c] == 0) iss = 0;
      end
      if (iss) begin
         void'(q_opc.pop_front());
         nd = '0;
         for (int c = 0; c < NCH; c++) begin
            if (h[c]) begin
               nd[c*DATAW +: DATAW] = mq[c][0];
               for (int k = 0; k < 15; k++) mq[c][k] = mq[c][k+1];
               mcnt[c]--;
            end
         end
         m_valid = 1; m_opc = h; m_data = nd;
      end else if (exec_ready) begin
         m_valid = 0;
      end
      if (acc_o) q_opc.push_back(axis_opcode_data);
      for (int c = 0; c < NCH; c++) begin
         if (acc_c[c]) begin
            mq[c][mcnt[c]] = axis_opnd_data[c*DATAW +: DATAW];
            mcnt[c]++;
         end
      end
      drain = m_sv && axis_status_ready;
      if (exec_done) begin
         if (!m_sv || drain) begin m_sv = 1; m_sd = exec_status; end
         else m_err = 1;
      end else if (drain) begin
         m_sv = 0;
      end
      @(posedge clk); #1;
   endtask

   task automatic apply_reset();
      #2; rst = 1'b1; #1;
      clear_model();
      compare_all();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic idle_inputs();
      axis_opcode_valid = 0; axis_opnd_valid = '0; exec_done = 0;
   endtask

   initial begin
      rst = 1'b0;
      axis_opcode_data = '0; axis_opcode_valid = 0;
      axis_opnd_data = '0; axis_opnd_valid = '0;
      exec_ready = 1; exec_done = 0; exec_status = ST_OK; axis_status_ready = 1;
      apply_reset();

      // Basic issue with A and B selected
      axis_opcode_data = 8'h03; axis_opcode_valid = 1;
      axis_opnd_data = {16'h0000, 16'h2222, 16'h1111}; axis_opnd_valid = 3'b011;
      tick();
      idle_inputs();
      check("t1_not_yet", exec_valid, 1'b0);
      tick();
      check("t1_valid", exec_valid, 1'b1);
      check("t1_opcode", exec_opcode, 8'h03);
      check("t1_data", exec_data, 48'h0000_2222_1111);

      // Missing M operand holds issue until it arrives
      axis_opcode_data = 8'h07; axis_opcode_valid = 1;
      axis_opnd_data = {16'h0000, 16'h4444, 16'h3333}; axis_opnd_valid = 3'b011;
      tick();
      idle_inputs();
      tick(); tick();
      check("t2_blocked", exec_valid, 1'b0);
      axis_opnd_data = {16'hBEEF, 32'h0}; axis_opnd_valid = 3'b100;
      tick();
      idle_inputs();
      check("t2_still_blocked", exec_valid, 1'b0);
      tick();
      check("t2_opcode", exec_opcode, 8'h07);
      check("t2_data", exec_data, 48'hBEEF_4444_3333);

      // Fill opcode FIFO while the core stalls
      exec_ready = 0;
      for (int k = 1; k <= 8; k++) begin
         axis_opcode_data = 8'(k * 8); axis_opcode_valid = 1;
         tick();
         check("t3_level", opc_level, k);
         check("t4_request_fill", stream_request, k <= REQTHR);
      end
      check("t3_full", axis_opcode_ready, 1'b0);
      axis_opcode_data = 8'hF8;
      tick();
      check("t3_level_held", opc_level, 8);
      idle_inputs();
      exec_ready = 1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check("t3_issue_opcode", exec_opcode, 8'(k * 8));
         check("t4_request_drain", stream_request, (8 - k) <= REQTHR);
      end

      // Status overflow while the sink stalls
      axis_status_ready = 0;
      exec_done = 1; exec_status = ST_ERR;
      tick();
      exec_status = ST_BUSY;
      tick();
      exec_done = 0;
      tick();
      check("t5_data_held", axis_status_data, ST_ERR);
      check("t5_overflow", err_overflow, 1'b1);
      axis_status_ready = 1;
      tick();
      check("t5_drained", axis_status_valid, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         axis_opcode_data  = 8'($urandom);
         axis_opcode_valid = ($urandom_range(0, 3) != 0);
         axis_opnd_data    = {16'($urandom), 16'($urandom), 16'($urandom)};
         axis_opnd_valid   = 3'($urandom);
         exec_ready        = ($urandom_range(0, 3) != 0);
         exec_done         = ($urandom_range(0, 3) == 0);
         exec_status       = 2'($urandom);
         axis_status_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      idle_inputs();
      exec_ready = 1; axis_status_ready = 1;

      // Reset while commands are queued and one is presented
      apply_reset();
      exec_ready = 0;
      for (int k = 0; k < 4; k++) begin
         axis_opcode_data = 8'h10 + 8'(k * 8); axis_opcode_valid = 1;
         tick();
      end
      idle_inputs();
      check("t6_valid_before", exec_valid, 1'b1);
      check("t6_level_before", opc_level, 3);
      apply_reset();
      check("t6_level_after", opc_level, 0);
      check("t6_valid_after", exec_valid, 1'b0);
      exec_ready = 1;
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
